// File: rtl/mips_store_buffer_if.sv
// ---------------------------------------------------------------------------
// mips_store_buffer_if
//   Bundles the CPU MEM-stage data port, the data-RAM read/write port and
//   the buffer status lines used by the hazard unit.
//
//   CPU side  : cpu_memwrite, cpu_memaddr, cpu_memwritedata -> buffer
//               cpu_memreaddata                              <- buffer
//   RAM side  : ram_raddr, ram_we, ram_waddr, ram_wdata      <- buffer
//               ram_rdata, ram_ack                           -> buffer
//   Status    : wb_full, wb_empty, wb_count, wb_overflow     <- buffer
//
//   modport slave  : the store buffer itself
//   modport master : the surrounding CPU / RAM environment
// ---------------------------------------------------------------------------
interface mips_store_buffer_if #(
  parameter int CW = 3
);

  logic          cpu_memwrite;
  logic [31:0]   cpu_memaddr;
  logic [31:0]   cpu_memwritedata;
  logic [31:0]   cpu_memreaddata;

  logic [31:0]   ram_raddr;
  logic [31:0]   ram_rdata;
  logic          ram_we;
  logic [31:0]   ram_waddr;
  logic [31:0]   ram_wdata;
  logic          ram_ack;

  logic          wb_full;
  logic          wb_empty;
  logic [CW-1:0] wb_count;
  logic          wb_overflow;

  modport slave (
    input  cpu_memwrite,
    input  cpu_memaddr,
    input  cpu_memwritedata,
    output cpu_memreaddata,
    output ram_raddr,
    input  ram_rdata,
    output ram_we,
    output ram_waddr,
    output ram_wdata,
    input  ram_ack,
    output wb_full,
    output wb_empty,
    output wb_count,
    output wb_overflow
  );

  modport master (
    output cpu_memwrite,
    output cpu_memaddr,
    output cpu_memwritedata,
    input  cpu_memreaddata,
    input  ram_raddr,
    output ram_rdata,
    input  ram_we,
    input  ram_waddr,
    input  ram_wdata,
    output ram_ack,
    input  wb_full,
    input  wb_empty,
    input  wb_count,
    input  wb_overflow
  );

endinterface

// File: rtl/mips_store_buffer.sv
// ---------------------------------------------------------------------------
// mips_store_buffer
//   Posted-write store buffer between the CPU MEM stage and the data RAM.
//   Stores retire into a circular FIFO in one cycle and drain to RAM in
//   program order over a req/ack handshake. Loads read RAM combinationally,
//   but the youngest buffered store to the same word overrides the RAM data.
//
// Ports
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high reset
//   bus    : mips_store_buffer_if.slave (CPU port, RAM port, status)
//
// Parameters
//   DEPTH  : number of entries (power of two, >= 2)
//   CW     : count width, log2(DEPTH)+1
//
// Optional feature
//   STORE_BUF_COALESCE_EN : when defined, a store to the same word as the
//   youngest entry overwrites that entry in place, unless the youngest entry
//   is also the head currently being offered to RAM (count == 1).
// ---------------------------------------------------------------------------
module mips_store_buffer #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic               clk,
  input  logic               reset,
  mips_store_buffer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  // Entry storage: word address and data, indexed by the circular pointers.
  logic [29:0]   addrMem_q [DEPTH];
  logic [31:0]   dataMem_q [DEPTH];

  logic [AW-1:0] headPtr_q, headPtr_d;
  logic [AW-1:0] tailPtr_q, tailPtr_d;
  logic [CW-1:0] count_q,   count_d;
  logic          overflow_q, overflow_d;

  logic [AW-1:0] youngestIdx;
  logic          isEmpty;
  logic          isFull;
  logic          pop;
  logic          coalesce;
  logic          push;
  logic          drop;
  logic [31:0]   fwdData;

  assign isEmpty     = (count_q == '0);
  assign isFull      = (count_q == CW'(DEPTH));
  assign youngestIdx = tailPtr_q - 1'b1;

  // An ack only retires the head when a write is actually being requested.
  assign pop = bus.ram_ack && !isEmpty;

`ifdef STORE_BUF_COALESCE_EN
  // Merge into the youngest entry only when it is not the head in flight;
  // with two or more entries the youngest can never be the head.
  assign coalesce = bus.cpu_memwrite
                  && (count_q >= CW'(2))
                  && (addrMem_q[youngestIdx] == bus.cpu_memaddr[31:2]);
`else
  assign coalesce = 1'b0;
`endif

  // A full buffer still accepts a store when the head retires at the same
  // edge, because the freed slot is reused immediately.
  assign push = bus.cpu_memwrite && !coalesce && (!isFull || pop);
  assign drop = bus.cpu_memwrite && !coalesce && isFull && !pop;

  // Next-state computation for pointers, occupancy and the sticky overflow.
  always_comb begin
    headPtr_d  = headPtr_q;
    tailPtr_d  = tailPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (pop) begin
      headPtr_d = headPtr_q + 1'b1;
    end
    if (push) begin
      tailPtr_d = tailPtr_q + 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);
    if (drop) begin
      overflow_d = 1'b1;
    end
  end

  // Control state; reset abandons every entry and any pending handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      headPtr_q  <= '0;
      tailPtr_q  <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      headPtr_q  <= headPtr_d;
      tailPtr_q  <= tailPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage needs no reset: validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      addrMem_q[tailPtr_q] <= bus.cpu_memaddr[31:2];
      dataMem_q[tailPtr_q] <= bus.cpu_memwritedata;
    end
`ifdef STORE_BUF_COALESCE_EN
    if (coalesce) begin
      dataMem_q[youngestIdx] <= bus.cpu_memwritedata;
    end
`endif
  end

  // Load forwarding: walk valid entries from oldest to youngest so the last
  // match (the youngest store to that word) wins over older ones and RAM.
  // The head still counts as valid during the cycle it is being acked.
  always_comb begin
    logic [AW-1:0] idx;
    fwdData = bus.ram_rdata;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = headPtr_q + AW'(i);
      if ((CW'(i) < count_q) && (addrMem_q[idx] == bus.cpu_memaddr[31:2])) begin
        fwdData = dataMem_q[idx];
      end
    end
  end

  assign bus.cpu_memreaddata = fwdData;
  assign bus.ram_raddr       = bus.cpu_memaddr;

  assign bus.ram_we          = !isEmpty;
  assign bus.ram_waddr       = {addrMem_q[headPtr_q], 2'b00};
  assign bus.ram_wdata       = dataMem_q[headPtr_q];

  assign bus.wb_full         = isFull;
  assign bus.wb_empty        = isEmpty;
  assign bus.wb_count        = count_q;
  assign bus.wb_overflow     = overflow_q;

endmodule

// File: tb/tb_mips_store_buffer.sv
// ---------------------------------------------------------------------------
// tb_mips_store_buffer
//   Directed scenarios with literal expectations followed by a randomized
//   phase. A queue-based model of the buffer is compared against the DUT on
//   every falling clock edge.
// ---------------------------------------------------------------------------
module tb_mips_store_buffer;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic clk;
  logic reset;

  mips_store_buffer_if #(.CW(CW)) bus ();

  mips_store_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] waddr;
    logic [31:0] data;
  } entry_t;

  entry_t modelQ[$];
  logic   modelOvf;
  int     checks;
  int     failures;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] expRead();
    for (int i = modelQ.size() - 1; i >= 0; i--) begin
      if (modelQ[i].waddr == bus.cpu_memaddr[31:2]) return modelQ[i].data;
    end
    return bus.ram_rdata;
  endfunction

  // Compare, then advance the model to what the coming rising edge produces.
  // Inputs are stable from here until that edge.
  always @(negedge clk) begin
    if (reset) begin
      modelQ.delete();
      modelOvf = 1'b0;
    end
    checkOutput("ram_we",      32'(bus.ram_we),      32'(modelQ.size() != 0));
    checkOutput("wb_count",    32'(bus.wb_count),    32'(modelQ.size()));
    checkOutput("wb_full",     32'(bus.wb_full),     32'(modelQ.size() == DEPTH));
    checkOutput("wb_empty",    32'(bus.wb_empty),    32'(modelQ.size() == 0));
    checkOutput("wb_overflow", 32'(bus.wb_overflow), 32'(modelOvf));
    checkOutput("ram_raddr",   bus.ram_raddr,        bus.cpu_memaddr);
    checkOutput("readdata",    bus.cpu_memreaddata,  expRead());
    if (modelQ.size() != 0) begin
      checkOutput("ram_waddr", bus.ram_waddr, {modelQ[0].waddr, 2'b00});
      checkOutput("ram_wdata", bus.ram_wdata, modelQ[0].data);
    end
    if (!reset) begin
      logic   popNow;
      logic   merged;
      entry_t e;
      popNow = bus.ram_ack && (modelQ.size() != 0);
      merged = 1'b0;
`ifdef STORE_BUF_COALESCE_EN
      if (bus.cpu_memwrite && modelQ.size() >= 2
          && modelQ[modelQ.size()-1].waddr == bus.cpu_memaddr[31:2]) begin
        modelQ[modelQ.size()-1].data = bus.cpu_memwritedata;
        merged = 1'b1;
      end
`endif
      if (popNow) void'(modelQ.pop_front());
      if (bus.cpu_memwrite && !merged) begin
        if (modelQ.size() < DEPTH) begin
          e.waddr = bus.cpu_memaddr[31:2];
          e.data  = bus.cpu_memwritedata;
          modelQ.push_back(e);
        end else begin
          modelOvf = 1'b1;
        end
      end
    end
  end

  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] data,
                               input logic ack, input logic [31:0] rdata);
    bus.cpu_memwrite     = we;
    bus.cpu_memaddr      = addr;
    bus.cpu_memwritedata = data;
    bus.ram_ack          = ack;
    bus.ram_rdata        = rdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    modelOvf = 1'b0;
    reset    = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    reset = 1'b0;
    #1;
    checkOutput("reset_empty", 32'(bus.wb_empty),    32'd1);
    checkOutput("reset_count", 32'(bus.wb_count),    32'd0);
    checkOutput("reset_ovf",   32'(bus.wb_overflow), 32'd0);
    checkOutput("reset_we",    32'(bus.ram_we),      32'd0);

    // Reset mid-drain: outputs clear immediately, no write after release.
    applyStimulus(1'b1, 32'h080, 32'h11, 1'b0, 32'h0); tick();
    applyStimulus(1'b1, 32'h084, 32'h22, 1'b0, 32'h0); tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    #1;
    checkOutput("middrain_count_pre", 32'(bus.wb_count), 32'd2);
    reset = 1'b1;
    #1;
    checkOutput("middrain_we",    32'(bus.ram_we),   32'd0);
    checkOutput("middrain_count", 32'(bus.wb_count), 32'd0);
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    checkOutput("postreset_we", 32'(bus.ram_we), 32'd0);

    // Forwarding hit versus RAM fall-through.
    applyStimulus(1'b1, 32'h100, 32'hAAAA, 1'b0, 32'h0); tick();
    applyStimulus(1'b1, 32'h104, 32'hBBBB, 1'b0, 32'h0); tick();
    applyStimulus(1'b0, 32'h100, 32'h0, 1'b0, 32'h1234); #1;
    checkOutput("fwd_hit", bus.cpu_memreaddata, 32'hAAAA);
    applyStimulus(1'b0, 32'h102, 32'h0, 1'b0, 32'h1234); #1;
    checkOutput("fwd_hit_lowbits", bus.cpu_memreaddata, 32'hAAAA);
    applyStimulus(1'b0, 32'h108, 32'h0, 1'b0, 32'h1234); #1;
    checkOutput("fwd_miss", bus.cpu_memreaddata, 32'h1234);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h0); tick(); tick();
    checkOutput("drained_empty", 32'(bus.wb_empty), 32'd1);

    // Two stores to one word: youngest forwards, RAM sees both in order.
    applyStimulus(1'b1, 32'h200, 32'd1, 1'b0, 32'h0); tick();
    applyStimulus(1'b1, 32'h200, 32'd2, 1'b0, 32'h0); tick();
    applyStimulus(1'b0, 32'h200, 32'h0, 1'b0, 32'h55); #1;
    checkOutput("youngest_fwd", bus.cpu_memreaddata, 32'd2);
    applyStimulus(1'b0, 32'h200, 32'h0, 1'b1, 32'h55); #1;
    checkOutput("order_w1", bus.ram_wdata, 32'd1);
    tick();
    checkOutput("order_w2", bus.ram_wdata, 32'd2);
    checkOutput("order_a2", bus.ram_waddr, 32'h200);
    tick();
    checkOutput("order_empty", 32'(bus.wb_empty), 32'd1);

    // Full buffer: accepted with ack, dropped without.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 32'h400 + 32'(4 * i), 32'h40 + 32'(i), 1'b0, 32'h0); tick();
    end
    checkOutput("full_flag",  32'(bus.wb_full),  32'd1);
    checkOutput("full_count", 32'(bus.wb_count), 32'd4);
    applyStimulus(1'b1, 32'h410, 32'h44, 1'b1, 32'h0); tick();
    checkOutput("full_accept_count", 32'(bus.wb_count),    32'd4);
    checkOutput("full_accept_ovf",   32'(bus.wb_overflow), 32'd0);
    checkOutput("full_accept_head",  bus.ram_waddr,        32'h404);
    applyStimulus(1'b1, 32'h414, 32'h45, 1'b0, 32'h0); tick();
    checkOutput("drop_count", 32'(bus.wb_count),    32'd4);
    checkOutput("drop_ovf",   32'(bus.wb_overflow), 32'd1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput("full_drain_addr", bus.ram_waddr, 32'h404 + 32'(4 * i));
      tick();
    end
    checkOutput("full_drain_ovf_sticky", 32'(bus.wb_overflow), 32'd1);
    doReset();

    // Ack held high with a store every cycle: occupancy stays at one.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 32'h700 + 32'(4 * k), 32'h70 + 32'(k), 1'b1, 32'h0);
      #1;
      if (k > 0) begin
        checkOutput("stream_addr",  bus.ram_waddr,       32'h700 + 32'(4 * (k - 1)));
        checkOutput("stream_data",  bus.ram_wdata,       32'h70 + 32'(k - 1));
        checkOutput("stream_count", 32'(bus.wb_count),   32'd1);
      end
      tick();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h0); tick();
    checkOutput("stream_empty", 32'(bus.wb_empty), 32'd1);

    // Same word twice behind a busy head: merged only with coalescing.
    applyStimulus(1'b1, 32'h500, 32'd9, 1'b0, 32'h0); tick();
    applyStimulus(1'b1, 32'h300, 32'd5, 1'b0, 32'h0); tick();
    applyStimulus(1'b1, 32'h300, 32'd7, 1'b0, 32'h0); tick();
`ifdef STORE_BUF_COALESCE_EN
    checkOutput("coal_count", 32'(bus.wb_count), 32'd2);
`else
    checkOutput("coal_count", 32'(bus.wb_count), 32'd3);
`endif
    applyStimulus(1'b0, 32'h300, 32'h0, 1'b1, 32'h0); #1;
    checkOutput("coal_fwd", bus.cpu_memreaddata, 32'd7);
    tick();
    checkOutput("coal_ram_addr", bus.ram_waddr, 32'h300);
`ifdef STORE_BUF_COALESCE_EN
    checkOutput("coal_ram_data", bus.ram_wdata, 32'd7);
`else
    checkOutput("coal_ram_data", bus.ram_wdata, 32'd5);
`endif
    tick(); tick();
    doReset();

    // Randomized traffic over a few colliding word addresses.
    for (int n = 0; n < 2000; n++) begin
      applyStimulus(1'($urandom_range(0, 1)),
                    32'h600 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3)),
                    $urandom,
                    ($urandom_range(0, 9) < 4),
                    $urandom);
      if ($urandom_range(0, 499) == 0) reset = 1'b1;
      tick();
      reset = 1'b0;
    end

    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
